clk_period_meter: RTL and testbench

- Measures the period and high time of a slow clock, such as a divider output, in i_clk cycles; the slow clock arrives on an input pin.
- Acts as the receiving/checking end of the team's clock dividers. It is used on-chip for divider self-check and on the bench to confirm the frequency ratio and duty cycle.
- Synchronizes the monitored clock, detects its edges, and counts i_clk cycles between edges.
- Reports each completed measurement with a one-cycle valid pulse and flags a stalled input.

---
 rtl/clk_meter_pkg.sv | 24 ++
 rtl/sync_edge_det.sv | 42 ++++
 rtl/clk_period_meter.sv | 115 +++++++++++
 tb/tb_clk_period_meter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter.
//   meter_state_t    : FSM state encoding (IDLE, ARM, RUN)
//   MIN_SYNC_STAGES  : smallest legal synchronizer depth
//   timeout_limit()  : counter value that ends a measurement with no rising edge
package clk_meter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } meter_state_t;

   localparam int unsigned MIN_SYNC_STAGES = 2;

   // 2^w - 2: the last count that still yields a representable period (2^w - 1).
   function automatic int unsigned timeout_limit(input int unsigned w);
      return (32'd1 << w) - 32'd2;
   endfunction

   function automatic bit sync_stages_ok(input int unsigned n);
      return n >= MIN_SYNC_STAGES;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain with rise/fall pulse generation for an asynchronous input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset; clears all flops
//   d     : asynchronous input
//   rise  : one-cycle pulse, synchronized level went 0 -> 1
//   fall  : one-cycle pulse, synchronized level went 1 -> 0
module sync_edge_det
   import clk_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
      $error("sync_edge_det: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] chain;
   logic                   s_d;
   logic                   s;

   assign s = chain[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
         s_d   <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], d};
         s_d   <= s;
      end
   end

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of a slow,
// asynchronous clock in i_clk cycles.
//   i_clk     : system clock
//   i_rst_n   : asynchronous active-low reset
//   i_en      : measurement enable (level)
//   i_div_clk : monitored slow clock
//   o_period  : last measured period
//   o_high    : last measured high time
//   o_valid   : one-cycle pulse when o_period/o_high update
//   o_timeout : sticky, no rising edge within the counter range
//
// state | meaning
// IDLE  | disabled, counters cleared, outputs hold
// ARM   | waiting for the first rise; preceding period unknown
// RUN   | counting between rises, reporting each complete period
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_div_clk,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_timeout
);

   // Compare one count early so the timeout registers on the same edge
   // the counter would reach the limit.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_limit(CNT_W) - 1);

   meter_state_t     state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hi;
   logic             r_fell;
   logic             rise;
   logic             fall;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .d    (i_div_clk),
      .rise (rise),
      .fall (fall)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_fell    <= 1'b0;
         o_period  <= '0;
         o_high    <= '0;
         o_valid   <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (!i_en) begin
            state  <= IDLE;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_fell <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state  <= ARM;
                  r_cnt  <= '0;
                  r_hi   <= '0;
                  r_fell <= 1'b0;
               end
               ARM: begin
                  if (rise) begin
                     state  <= RUN;
                     r_cnt  <= '0;
                     r_fell <= 1'b0;
                  end
               end
               RUN: begin
                  if (rise) begin
                     r_cnt  <= '0;
                     r_fell <= 1'b0;
                     // A rise without a preceding fall is a restart, not a result.
                     if (r_fell) begin
                        o_period  <= r_cnt + 1'b1;
                        o_high    <= r_hi;
                        o_valid   <= 1'b1;
                        o_timeout <= 1'b0;
                     end
                  end else if (r_cnt == CNT_LAST) begin
                     o_timeout <= 1'b1;
                     state     <= ARM;
                     r_cnt     <= '0;
                     r_fell    <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (fall) begin
                        r_hi   <= r_cnt + 1'b1;
                        r_fell <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter (CNT_W = 4 so timeouts are reachable).
// The monitored clock is driven synchronously just after each i_clk edge, so the
// synchronizer delay is fixed. The reference model works on pad edge timestamps:
// a rise at pad index k becomes visible at edge k + SYNC + 1.
module tb_clk_period_meter;

   localparam int CNT_W = 4;
   localparam int SYNC  = 2;
   localparam int LIMIT = (1 << CNT_W) - 2;
   localparam int LAT   = SYNC + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             div_clk = 1'b0;
   logic [CNT_W-1:0] o_period;
   logic [CNT_W-1:0] o_high;
   logic             o_valid;
   logic             o_timeout;

   clk_period_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC)
   ) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_en     (en),
      .i_div_clk(div_clk),
      .o_period (o_period),
      .o_high   (o_high),
      .o_valid  (o_valid),
      .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      bit is_to;
      int per;
      int hi;
   } ev_t;

   ev_t q[$];
   int  n = 0;
   int  checks = 0;
   int  errors = 0;
   bit  cur_en = 1'b0;
   bit  prev = 1'b0;
   bit  m_en = 1'b0;
   bit  m_run = 1'b0;
   int  m_last = 0;
   int  m_fall = -1;
   int  exp_per = 0;
   int  exp_hi = 0;
   bit  exp_to = 1'b0;
   bit  exp_v = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d edge=%0d", tag, obs, expv, n);
      end
   endtask

   // Event-level reference: periods and high times from pad edge timestamps.
   task automatic model(input bit pad);
      bit r;
      bit f;
      ev_t e;
      r = pad & ~prev;
      f = ~pad & prev;
      if (m_run) begin
         if (r) begin
            if (m_fall >= 0) begin
               e.due = n + LAT; e.is_to = 1'b0; e.per = n - m_last; e.hi = m_fall - m_last;
               q.push_back(e);
            end
            m_last = n;
            m_fall = -1;
         end else if (n - m_last == LIMIT) begin
            e.due = n + LAT; e.is_to = 1'b1; e.per = 0; e.hi = 0;
            q.push_back(e);
            m_run = 1'b0;
         end else if (f) begin
            m_fall = n;
         end
      end else if (r) begin
         m_run  = 1'b1;
         m_last = n;
         m_fall = -1;
      end
   endtask

   task automatic step(input bit pad);
      ev_t e;
      @(posedge clk);
      n++;
      #1;
      exp_v = 1'b0;
      while (q.size() > 0 && q[0].due <= n) begin
         e = q.pop_front();
         if (e.is_to) exp_to = 1'b1;
         else begin
            exp_v   = 1'b1;
            exp_per = e.per;
            exp_hi  = e.hi;
            exp_to  = 1'b0;
         end
      end
      chk("valid", o_valid, exp_v);
      chk("period", o_period, exp_per);
      chk("high", o_high, exp_hi);
      chk("timeout", o_timeout, exp_to);
      en      = cur_en;
      div_clk = pad;
      if (!cur_en) begin
         m_en  = 1'b0;
         m_run = 1'b0;
      end else if (!m_en) begin
         m_en  = 1'b1;
         m_run = 1'b0;
      end
      if (m_en && rst_n) model(pad);
      prev = rst_n ? pad : 1'b0;
   endtask

   task automatic run(input bit pad, input int k);
      repeat (k) step(pad);
   endtask

   task automatic per(input int hi, input int lo);
      run(1'b1, hi);
      run(1'b0, lo);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      exp_per = 0;
      exp_hi  = 0;
      exp_to  = 1'b0;
      m_run   = 1'b0;
      m_fall  = -1;
      prev    = 1'b0;
   endtask

   initial begin
      // reset state
      run(1'b0, 3);
      rst_n = 1'b1;
      run(1'b0, 2);
      cur_en = 1'b1;
      run(1'b0, 3);

      // divide by 6, 50% duty
      repeat (7) per(3, 3);
      // divide by 5, 1-cycle high pulse
      repeat (7) per(1, 4);

      // input stops low -> timeout, then restart
      repeat (2) per(3, 3);
      run(1'b0, 20);
      repeat (3) per(3, 3);

      // input held high -> timeout without a high-time update
      per(3, 3);
      run(1'b1, 20);
      run(1'b0, 3);
      repeat (3) per(2, 4);

      // random waveforms, gaps above the limit produce timeouts
      repeat (40) per($urandom_range(1, 8), $urandom_range(1, 8));

      // enable dropped mid-period for 10 cycles
      repeat (2) per(3, 9);
      run(1'b1, 3);
      run(1'b0, 4);
      cur_en = 1'b0;
      run(1'b0, 4);
      run(1'b1, 3);
      run(1'b0, 3);
      cur_en = 1'b1;
      run(1'b0, 3);
      repeat (4) per(3, 3);

      // reset pulsed mid-period
      repeat (2) per(3, 3);
      run(1'b1, 2);
      do_reset();
      run(1'b0, 3);
      rst_n = 1'b1;
      run(1'b0, 3);
      repeat (5) per(3, 3);
      run(1'b0, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
